// File: rtl/powlib_iparb.sv
//==============================================================================
// Module   : powlib_iparb
// Purpose  : Round-robin burst arbiter sharing one registered powlib bus port
//            between N requesters. Define POWLIB_IPARB_PRIO_EN to give
//            requester 0 priority in IDLE.
// Revision : 1.0  initial release
//==============================================================================
`ifndef POWLIB_BW
`define POWLIB_BW 8
`endif
`ifndef POWLIB_OPW
`define POWLIB_OPW 4
`endif

`default_nettype none

module powlib_iparb #(
    parameter string ID      = "IPARB",
    parameter int    EDBG    = 0,
    parameter int    N       = 4,
    parameter int    B_BPD   = 4,
    parameter int    B_AW    = `POWLIB_BW*B_BPD,
    parameter int    GNT_MAX = 4,
    localparam int   B_WW    = `POWLIB_OPW+B_BPD+`POWLIB_BW*B_BPD,
    localparam int   IW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N*B_AW-1:0]   inaddr,
    input  logic [N*B_WW-1:0]   indata,
    input  logic [N-1:0]        invld,
    output logic [N-1:0]        inrdy,
    output logic [B_AW-1:0]     outaddr,
    output logic [B_WW-1:0]     outdata,
    output logic                outvld,
    input  logic                outrdy,
    input  logic                outnf,
    output logic [IW-1:0]       gntidx,
    output logic                gntvld
);

    localparam int CW = $clog2(GNT_MAX+1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    if (N < 2) begin : g_chk_n
        $fatal(1, "%s: N=%0d must be >= 2", ID, N);
    end
    if (GNT_MAX < 1) begin : g_chk_gnt
        $fatal(1, "%s: GNT_MAX=%0d must be >= 1", ID, GNT_MAX);
    end
    if (EDBG != 0) begin : g_edbg
        $info("%s: N=%0d GNT_MAX=%0d", ID, N, GNT_MAX);
    end

    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic [CW-1:0] cnt;
    logic          any_vld;
    logic          sel_vld;
    logic          slot_free;
    logic          xfer;
    logic          done;

    assign any_vld   = |invld;
    assign sel_vld   = invld[gntidx];
    assign slot_free = (!outvld || outrdy) && !outnf;
    assign xfer      = sel_vld && inrdy[gntidx];
    assign done      = (xfer && (cnt == CW'(GNT_MAX-1))) || (!xfer && !sel_vld);

    // Upward search from ptr with explicit wrap so non-power-of-2 N works.
    always_comb begin
        int  idx;
        logic found;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && invld[IW'(idx)]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
`ifdef POWLIB_IPARB_PRIO_EN
        if (invld[0]) win = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_vld) state_nxt = S_GRANT;
            S_GRANT: if (done)    state_nxt = S_IDLE;
            default:              state_nxt = S_IDLE;
        endcase
    end

    // rst is folded in so no requester sees a ready while reset is held.
    always_comb begin
        inrdy  = '0;
        gntvld = (state == S_GRANT);
        if (rst && state == S_GRANT) inrdy[gntidx] = slot_free;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr     <= '0;
            gntidx  <= '0;
            cnt     <= '0;
            outvld  <= 1'b0;
            outaddr <= '0;
            outdata <= '0;
        end else begin
            if (state == S_IDLE && any_vld) begin
                gntidx <= win;
                cnt    <= '0;
            end
            if (xfer) cnt <= cnt + CW'(1);
            if (state == S_GRANT && done)
                ptr <= (gntidx == IW'(N-1)) ? '0 : gntidx + IW'(1);
            if (xfer) begin
                outaddr <= inaddr[int'(gntidx)*B_AW +: B_AW];
                outdata <= indata[int'(gntidx)*B_WW +: B_WW];
                outvld  <= 1'b1;
            end else if (outrdy) begin
                outvld  <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
